// File: rtl/bcd_display_scan.sv
// Multiplexed 4-digit common-anode 7-segment scanner for three BCD digits.
// Loaded digits are held pending and applied only at frame boundaries.
module bcd_display_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_ZEROS = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cargar,
    input  logic [3:0] unidad,
    input  logic [3:0] decena,
    input  logic [3:0] centena,
    output logic [3:0] anodos,
    output logic [6:0] segmentos,
    output logic       punto,
    output logic       actualizado
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    // slot_q is the slot that the next tick puts on the display
    logic [1:0]    slot_q, slot_d;
    logic [11:0]   pend_q, pend_d;
    logic          pend_valid_q, pend_valid_d;
    logic [11:0]   act_q, act_d;
    logic [3:0]    anodos_q, anodos_d;
    logic [6:0]    segmentos_q, segmentos_d;
    logic          actualizado_q, actualizado_d;

    logic          tick_s;
    logic          apply_s;
    logic [3:0]    cen_s, dec_s, uni_s;

    // Next-state logic: prescaler, slot scan, double buffer and output decode
    always_comb begin
        tick_s       = (presc_q == PRESC_LAST);
        apply_s      = tick_s && (slot_q == 2'd3) && pend_valid_q;
        presc_d      = tick_s ? {PW{1'b0}} : presc_q + PW'(1);
        slot_d       = tick_s ? slot_q + 2'd1 : slot_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        act_d        = apply_s ? pend_q : act_q;

        if (cargar) begin
            pend_d       = {centena, decena, unidad};
            pend_valid_d = 1'b1;
        end else if (apply_s) begin
            pend_valid_d = 1'b0;
        end else begin
            pend_valid_d = pend_valid_q;
        end

        cen_s         = act_d[11:8];
        dec_s         = act_d[7:4];
        uni_s         = act_d[3:0];
        anodos_d      = anodos_q;
        segmentos_d   = segmentos_q;
        actualizado_d = apply_s;

        if (tick_s) begin
            case (slot_q)
                2'd0: begin
                    anodos_d    = 4'b1110;
                    segmentos_d = seg_decode(uni_s);
                end
                2'd1: begin
                    anodos_d    = 4'b1101;
                    segmentos_d = (BLANK_ZEROS && (cen_s == 4'd0) && (dec_s == 4'd0))
                                  ? 7'h7F : seg_decode(dec_s);
                end
                2'd2: begin
                    anodos_d    = 4'b1011;
                    segmentos_d = (BLANK_ZEROS && (cen_s == 4'd0)) ? 7'h7F : seg_decode(cen_s);
                end
                default: begin
                    anodos_d    = 4'b1111;
                    segmentos_d = 7'h7F;
                end
            endcase
        end else begin
            anodos_d    = anodos_q;
            segmentos_d = segmentos_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q       <= {PW{1'b0}};
            slot_q        <= 2'd0;
            pend_q        <= 12'd0;
            pend_valid_q  <= 1'b0;
            act_q         <= 12'd0;
            anodos_q      <= 4'b1111;
            segmentos_q   <= 7'h7F;
            actualizado_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            slot_q        <= slot_d;
            pend_q        <= pend_d;
            pend_valid_q  <= pend_valid_d;
            act_q         <= act_d;
            anodos_q      <= anodos_d;
            segmentos_q   <= segmentos_d;
            actualizado_q <= actualizado_d;
        end
    end

    assign anodos      = anodos_q;
    assign segmentos   = segmentos_q;
    assign actualizado = actualizado_q;
    assign punto       = 1'b1;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan: a cycle-count based model pushes the
// expected display state each clock, a negedge monitor pops and compares.
module tb_bcd_display_scan;

    localparam int RD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cargar = 1'b0;
    logic [3:0] unidad = 4'd0, decena = 4'd0, centena = 4'd0;
    logic [3:0] an1, an0;
    logic [6:0] seg1, seg0;
    logic       p1, p0, act1, act0;

    always #5 clk = ~clk;

    bcd_display_scan #(.REFRESH_DIV(RD), .BLANK_ZEROS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .cargar(cargar),
        .unidad(unidad), .decena(decena), .centena(centena),
        .anodos(an1), .segmentos(seg1), .punto(p1), .actualizado(act1));

    bcd_display_scan #(.REFRESH_DIV(RD), .BLANK_ZEROS(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .cargar(cargar),
        .unidad(unidad), .decena(decena), .centena(centena),
        .anodos(an0), .segmentos(seg0), .punto(p0), .actualizado(act0));

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] s1;
        logic [6:0] s0;
        logic       act;
    } exp_t;

    exp_t       expq[$];
    int         k = 0;
    logic [3:0] m_pend[3];
    logic [3:0] m_act[3];
    bit         m_pv = 1'b0;

    logic [6:0] dec_tab[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    task automatic chk(input string name, input logic [6:0] got, input logic [6:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [6:0] model_seg(input int s, input bit bz,
                                             input logic [3:0] u, input logic [3:0] d,
                                             input logic [3:0] c);
        if (s == 0) return dec_tab[u];
        if (s == 1) return (bz && c == 4'd0 && d == 4'd0) ? 7'h7F : dec_tab[d];
        if (s == 2) return (bz && c == 4'd0) ? 7'h7F : dec_tab[c];
        return 7'h7F;
    endfunction

    // Reference model: display position derived from cycles since reset release
    always @(posedge clk) begin
        exp_t       e;
        bit         pulse;
        int         s;
        logic [3:0] one;
        one = 4'b0001;
        if (!rst_n) begin
            k    = 0;
            m_pv = 1'b0;
            for (int i = 0; i < 3; i++) begin
                m_pend[i] = 4'd0;
                m_act[i]  = 4'd0;
            end
            e = '{4'hF, 7'h7F, 7'h7F, 1'b0};
        end else begin
            k++;
            pulse = 1'b0;
            if ((k % RD == 0) && ((k / RD) % 4 == 0) && m_pv) begin
                m_act = m_pend;
                pulse = 1'b1;
            end
            if (cargar) begin
                m_pend[0] = unidad;
                m_pend[1] = decena;
                m_pend[2] = centena;
                m_pv      = 1'b1;
            end else if (pulse) begin
                m_pv = 1'b0;
            end
            if (k < RD) begin
                e = '{4'hF, 7'h7F, 7'h7F, 1'b0};
            end else begin
                s     = ((k / RD) - 1) % 4;
                e.an  = (s == 3) ? 4'hF : ~(one << s);
                e.s1  = model_seg(s, 1'b1, m_act[0], m_act[1], m_act[2]);
                e.s0  = model_seg(s, 1'b0, m_act[0], m_act[1], m_act[2]);
                e.act = pulse;
            end
        end
        expq.push_back(e);
    end

    // Monitor: compare both DUTs against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            if (!rst_n) e = '{4'hF, 7'h7F, 7'h7F, 1'b0};
            chk("anodos_bz1", {3'b000, an1}, {3'b000, e.an});
            chk("segmentos_bz1", seg1, e.s1);
            chk("punto_bz1", {6'd0, p1}, 7'd1);
            chk("actualizado_bz1", {6'd0, act1}, {6'd0, e.act});
            chk("anodos_bz0", {3'b000, an0}, {3'b000, e.an});
            chk("segmentos_bz0", seg0, e.s0);
            chk("punto_bz0", {6'd0, p0}, 7'd1);
            chk("actualizado_bz0", {6'd0, act0}, {6'd0, e.act});
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [3:0] c, input logic [3:0] d, input logic [3:0] u);
        cargar  = 1'b1;
        centena = c;
        decena  = d;
        unidad  = u;
        @(posedge clk);
        #1;
        cargar  = 1'b0;
        centena = 4'($urandom);
        decena  = 4'($urandom);
        unidad  = 4'($urandom);
    endtask

    task automatic wait_phase(input int ph);
        int g;
        g = 0;
        do begin
            @(posedge clk);
            #1;
            g++;
        end while ((k % 16 != ph) && (g < 100));
        checks++;
        if (k % 16 != ph) begin
            errors++;
            $display("FAIL wait_phase: got phase %0d expected %0d", k % 16, ph);
        end
    endtask

    initial begin
        logic [3:0] c, d, u;
        cycles(3);
        rst_n = 1'b1;
        cycles(40);

        wait_phase(6);
        load(4'd2, 4'd5, 4'd5);
        cycles(40);
        load(4'd0, 4'd0, 4'd7);
        cycles(40);
        load(4'd1, 4'd0, 4'd0);
        cycles(40);

        wait_phase(1);
        load(4'd1, 4'd2, 4'd3);
        cycles(3);
        load(4'd4, 4'd5, 4'd6);
        wait_phase(15);
        load(4'd7, 4'd8, 4'd9);
        cycles(40);

        load(4'd0, 4'd12, 4'd0);
        cycles(40);

        repeat (40) begin
            c = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            d = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            u = 4'($urandom_range(0, 15));
            load(c, d, u);
            cycles($urandom_range(0, 20));
        end
        cycles(40);

        wait_phase(5);
        load(4'd3, 4'd3, 4'd3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_anodos", {3'b000, an1}, 7'h0F);
        chk("async_rst_segmentos", seg1, 7'h7F);
        chk("async_rst_punto", {6'd0, p1}, 7'd1);
        chk("async_rst_actualizado", {6'd0, act1}, 7'd0);
        chk("async_rst_anodos_bz0", {3'b000, an0}, 7'h0F);
        chk("async_rst_segmentos_bz0", seg0, 7'h7F);
        cycles(3);
        rst_n = 1'b1;
        cycles(40);

        cycles(2);
        checks++;
        if (expq.size() > 2) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected <=2", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
- Downstream consumer of the byte-to-BCD converter.
- Takes three BCD digits (unidad, decena, centena) and drives a 4-digit multiplexed common-anode 7-segment display.
- Runs one digit at a time from a programmable refresh prescaler.
- New values are double-buffered and applied only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
REFRESH_DIV, 50000, clock cycles per digit slot (>=1); 50 MHz clock gives 1 kHz slot rate
BLANK_ZEROS, 1, 1 = blank leading zeros on centena/decena; 0 = always show all three digits

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cargar  in  1  load strobe, 1-cycle pulse; captures the digit inputs into the pending register
unidad  in  4  BCD units digit
decena  in  4  BCD tens digit
centena  in  4  BCD hundreds digit
anodos  out  4  digit enables, active-low; bit0 = rightmost digit
segmentos  out  7  segment drives, active-low, order {g,f,e,d,c,b,a}
punto  out  1  decimal point, active-low, held 1 (off)
actualizado  out  1  1-cycle pulse when pending digits are copied to the displayed set

Behaviour:
- Reset (async assert, sync deassert at the next clk edge):
  - prescaler=0, slot index=0, pending regs=0, active regs=0, pend_valid=0.
  - anodos=4'b1111, segmentos=7'h7F, punto=1, actualizado=0.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps to 0. tick=1 in the cycle the count equals REFRESH_DIV-1. With REFRESH_DIV=1, tick is high every cycle.
- Slot index: 2-bit, increments mod 4 on tick.
  - Slot 0 = unidad, anodos=1110.
  - Slot 1 = decena, anodos=1101.
  - Slot 2 = centena, anodos=1011.
  - Slot 3 = unused 4th digit, anodos=1111, segmentos=7F.
- Capture: on cargar=1, pending <= {centena,decena,unidad} and pend_valid <= 1. A later cargar before the frame boundary overwrites pending (last write wins).
- Frame boundary: the tick edge on which the index wraps 3->0.
  - If pend_valid=1: active <= pending, pend_valid <= 0, actualizado=1 for exactly that cycle.
  - If cargar=1 on that same edge: the new inputs go to pending, pend_valid stays 1, and active takes the previous pending value. The new value is applied at the next boundary.
- Outputs are registered. anodos and segmentos change on the same edge that advances the index and show the new slot, using the active set valid after that edge. Between ticks the outputs are stable. Segment data is never shown under the wrong anode.
- Decode (active-low, hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Any value 10-15 shows dash = 3F (g only).
- Leading-zero blanking (BLANK_ZEROS=1):
  - centena slot is blank (anodos still asserted, segmentos=7F) if centena==0.
  - decena slot is blank if centena==0 and decena==0.
  - unidad is never blanked; a value of 0 shows "0".
  - A dash digit counts as nonzero for blanking purposes.
- Reset mid-frame: everything returns to reset values immediately. The first slot after release is slot 0 after REFRESH_DIV cycles, showing blank-decoded zeros (unidad shows "0").
- Inputs are sampled only when cargar=1; changes at any other time are ignored.

Test Plan:
- Reset, then release with no cargar, REFRESH_DIV=4 -> anodos 1111/7F for 4 cycles, then the cycle 1110/40, 1101/7F, 1011/7F, 1111/7F, repeating every 16 cycles. actualizado never pulses.
- cargar with centena=2, decena=5, unidad=5 mid-frame -> old frame completes unchanged. At the wrap, actualizado pulses once. Next frame shows slot0=12, slot1=12, slot2=24.
- Load 0,0,7 with BLANK_ZEROS=1 -> 78, 7F, 7F. Load 0,0,7 with BLANK_ZEROS=0 -> 78, 40, 40. Load 1,0,0 -> 40, 40, 79.
- Two cargar pulses (1,2,3 then 4,5,6) in one frame -> only 6,5,4 is ever displayed. Then cargar exactly on the wrap edge with 7,8,9 -> the next frame shows the previous pending value and the following frame shows 9,8,7.
- Digit value 12 on decena with centena=0 -> decena slot shows 3F, not blanked. Unidad=0 still shows 40.
- Assert rst_n low mid-slot -> outputs go to 1111/7F/punto=1 asynchronously with no clock edge. After release, the active set is zeros.
